// File: rtl/mem_read_arbiter_if.sv
// Burst read channel bundle (address phase + data beats) shared by the
// requester ports and the memory port of mem_read_arbiter.
interface mem_read_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  rlast;
   logic                  rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rvalid, rlast
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rvalid, rlast
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter serialising whole line-refill bursts onto one memory read channel.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 1 (dcache) wins ties.
//
// state | meaning
// IDLE  | no burst owned; sample requests, latch winner address
// ADDR  | address presented to memory until m.arready
// DATA  | beats steered to the granted requester until the rlast handshake
module mem_read_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BEAT_CNT_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   mem_read_arbiter_if.slave         s0,
   mem_read_arbiter_if.slave         s1,
   mem_read_arbiter_if.master        m,
   output logic                      busy,
   output logic                      grant_id,
   output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                    state_r, state_nxt;
   logic [ADDR_WIDTH-1:0]     addr_r, addr_nxt;
   logic                      grant_r, grant_nxt;
   logic [BEAT_CNT_WIDTH-1:0] cnt_r, cnt_nxt;
   logic                      any_req;
   logic                      win_id;
   logic                      sel_rready;

   assign any_req = s0.arvalid | s1.arvalid;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_r;

   always_comb begin
      if (s0.arvalid && s1.arvalid) begin
         win_id = ~last_grant_r;
      end else begin
         win_id = s1.arvalid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= 1'b1;
      end else if (state_r == ST_IDLE && any_req) begin
         last_grant_r <= win_id;
      end
   end
`else
   // A lone s0 request yields 0; any s1 request (alone or tied) yields 1.
   assign win_id = s1.arvalid;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
         grant_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt;
         addr_r  <= addr_nxt;
         grant_r <= grant_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_r;
      addr_nxt   = addr_r;
      grant_nxt  = grant_r;
      cnt_nxt    = cnt_r;
      sel_rready = 1'b0;

      m.araddr   = '0;
      m.arvalid  = 1'b0;
      m.rready   = 1'b0;
      s0.arready = 1'b0;
      s1.arready = 1'b0;
      s0.rdata   = '0;
      s1.rdata   = '0;
      s0.rvalid  = 1'b0;
      s1.rvalid  = 1'b0;
      s0.rlast   = 1'b0;
      s1.rlast   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (any_req) begin
               state_nxt = ST_ADDR;
               grant_nxt = win_id;
               addr_nxt  = win_id ? s1.araddr : s0.araddr;
            end
         end

         ST_ADDR: begin
            // The request is committed: a requester dropping arvalid does not abort it.
            m.arvalid = 1'b1;
            m.araddr  = addr_r;
            if (grant_r) begin
               s1.arready = m.arready;
            end else begin
               s0.arready = m.arready;
            end
            if (m.arready) begin
               state_nxt = ST_DATA;
            end
         end

         ST_DATA: begin
            if (grant_r) begin
               s1.rdata   = m.rdata;
               s1.rvalid  = m.rvalid;
               s1.rlast   = m.rlast;
               sel_rready = s1.rready;
            end else begin
               s0.rdata   = m.rdata;
               s0.rvalid  = m.rvalid;
               s0.rlast   = m.rlast;
               sel_rready = s0.rready;
            end
            m.rready = sel_rready;
            if (m.rvalid && sel_rready) begin
               if (cnt_r != {BEAT_CNT_WIDTH{1'b1}}) begin
                  cnt_nxt = cnt_r + 1'b1;
               end
               if (m.rlast) begin
                  state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign busy     = (state_r != ST_IDLE);
   assign grant_id = busy & grant_r;
   assign beat_cnt = cnt_r;

endmodule
